// File: rtl/irq_ctrl_if.sv
// Slave register bus shared by the system-bridge devices (timer counters, interrupt controller).
interface irq_ctrl_if;
   logic [3:2]  ADD_I;
   logic        WE_I;
   logic [31:0] DAT_I;
   logic [3:0]  be;
   logic [31:0] DAT_O;

   modport master (output ADD_I, WE_I, DAT_I, be, input DAT_O);
   modport slave  (input ADD_I, WE_I, DAT_I, be, output DAT_O);
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: latches/masks device IRQ lines and sequences one
// interrupt at a time to CP0 through a request / acknowledge / end-of-interrupt handshake.
module irq_ctrl #(
   parameter int N_SRC = 6,
   parameter int ID_W  = 3
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   irq_ctrl_if.slave        bus,
   input  logic [N_SRC-1:0] IRQ_I,
   input  logic             int_ack,
   output logic             irq_o,
   output logic [ID_W-1:0]  cur_id,
   output logic             in_svc
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] A_PEND = 2'b00;
   localparam logic [1:0] A_MASK = 2'b01;
   localparam logic [1:0] A_MODE = 2'b10;
   localparam logic [1:0] A_CUR  = 2'b11;

   state_t           state;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] mode;
   logic [N_SRC-1:0] irq_q;

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] active;
   logic [N_SRC-1:0] cur_onehot;
   logic [N_SRC-1:0] set_vec;
   logic [N_SRC-1:0] clr_vec;
   logic [N_SRC-1:0] pend_nxt;
   logic [ID_W-1:0]  win;
   logic             any_active;
   logic             cur_active;
   logic             wr_en;
   logic             w1c;
   logic             eoi;
   logic             ack_clr;
   logic [31:0]      cur_word;
   logic [31:0]      rd_data;
   logic             unused_bits;

   assign wr_en      = bus.WE_I & bus.be[0];
   assign w1c        = wr_en & (bus.ADD_I == A_PEND);
   assign eoi        = wr_en & (bus.ADD_I == A_CUR);
   assign ack_clr    = (state == ST_ASSERT) & int_ack;
   assign rise       = IRQ_I & ~irq_q;
   assign active     = pend & mask;
   assign any_active = |active;
   assign cur_active = |(active & cur_onehot);
   assign unused_bits = ^{bus.DAT_I, bus.be[3:1]};

   // One-hot decode of cur_id, used for the ack clear and the retract test.
   always_comb begin
      cur_onehot = {N_SRC{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         if (ID_W'(i) == cur_id) begin
            cur_onehot[i] = 1'b1;
         end else begin
            cur_onehot[i] = 1'b0;
         end
      end
   end

   // Lowest-numbered active source wins; scanning downward leaves the lowest index last.
   always_comb begin
      win = {ID_W{1'b0}};
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            win = ID_W'(i);
         end else begin
            win = win;
         end
      end
   end

   // Pending next-state: a set in the same cycle overrides any clear.
   always_comb begin
      set_vec = (mode & rise) | (~mode & IRQ_I);
      clr_vec = {N_SRC{1'b0}};
      if (w1c) begin
         clr_vec = clr_vec | bus.DAT_I[N_SRC-1:0];
      end else begin
         clr_vec = clr_vec;
      end
      if (ack_clr) begin
         clr_vec = clr_vec | (mode & cur_onehot);
      end else begin
         clr_vec = clr_vec;
      end
      pend_nxt = set_vec | (pend & ~clr_vec);
   end

   // Read mux; reflects register contents before the coming edge.
   always_comb begin
      cur_word            = 32'd0;
      cur_word[7]         = in_svc;
      cur_word[6]         = irq_o;
      cur_word[ID_W-1:0]  = cur_id;
      case (bus.ADD_I)
         A_PEND:  rd_data = 32'(pend);
         A_MASK:  rd_data = 32'(mask);
         A_MODE:  rd_data = 32'(mode);
         A_CUR:   rd_data = cur_word;
         default: rd_data = 32'd0;
      endcase
   end

   assign bus.DAT_O = rd_data;

   // Line sampling and software-visible registers.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         irq_q <= {N_SRC{1'b0}};
         pend  <= {N_SRC{1'b0}};
         mask  <= {N_SRC{1'b0}};
         mode  <= {N_SRC{1'b0}};
      end else begin
         irq_q <= IRQ_I;
         pend  <= pend_nxt;
         if (wr_en && (bus.ADD_I == A_MASK)) begin
            mask <= bus.DAT_I[N_SRC-1:0];
         end
         if (wr_en && (bus.ADD_I == A_MODE)) begin
            mode <= bus.DAT_I[N_SRC-1:0];
         end
      end
   end

   // Handshake FSM; cur_id is only loaded from IDLE so a later higher-priority source waits for EOI.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state  <= ST_IDLE;
         cur_id <= {ID_W{1'b0}};
         irq_o  <= 1'b0;
         in_svc <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_svc <= 1'b0;
               if (any_active) begin
                  cur_id <= win;
                  state  <= ST_ASSERT;
                  irq_o  <= 1'b1;
               end else begin
                  irq_o  <= 1'b0;
               end
            end
            ST_ASSERT: begin
               if (int_ack) begin
                  state  <= ST_SERVICE;
                  irq_o  <= 1'b0;
                  in_svc <= 1'b1;
               end else if (!cur_active) begin
                  state  <= ST_IDLE;
                  irq_o  <= 1'b0;
                  in_svc <= 1'b0;
               end else begin
                  irq_o  <= 1'b1;
                  in_svc <= 1'b0;
               end
            end
            ST_SERVICE: begin
               irq_o <= 1'b0;
               if (eoi) begin
                  state  <= ST_IDLE;
                  in_svc <= 1'b0;
               end else begin
                  in_svc <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               irq_o  <= 1'b0;
               in_svc <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Bus-mapped interrupt controller that collects IRQ lines from the timer counters and other bridge devices.
- It latches and masks those lines, picks one winner by fixed priority, and presents a single interrupt plus its source id to the CPU's CP0.
- It sequences each interrupt through a request/acknowledge/end-of-interrupt handshake.
- It sits on the system bridge beside the timer counters and uses the same slave register interface as they do.

Parameters:
- N_SRC, 6, number of interrupt sources. Legal range 1..8.
- ID_W, 3, width of the source id. Must satisfy 2^ID_W >= N_SRC.

Ports:
- CLK_I  input  1  system clock. All state changes on its rising edge.
- RST_I  input  1  asynchronous, active-high reset.
- ADD_I  input  [3:2]  register select: 00 PEND, 01 MASK, 10 MODE, 11 CUR.
- WE_I  input  1  write strobe. Acts for one cycle per cycle asserted.
- DAT_I  input  32  write data.
- be  input  4  byte enables. Only be[0] is used, because all fields sit in bits [7:0].
- DAT_O  output  32  read data. Combinational from ADD_I. Unused bits read 0.
- IRQ_I  input  N_SRC  device interrupt lines, synchronous to CLK_I. Bit 0 has the highest priority.
- int_ack  input  1  one-cycle acknowledge from CP0.
- irq_o  output  1  interrupt request to CP0.
- cur_id  output  ID_W  id of the source being requested or in service.
- in_svc  output  1  high while an acknowledged interrupt awaits EOI.

Behaviour:
- Reset:
  - pend, mask, mode, irq_q, cur_id are all 0.
  - FSM is in IDLE.
  - irq_o=0, in_svc=0.
  - DAT_O shows the selected register's reset value.
- Sampling:
  - irq_q <= IRQ_I every cycle.
  - rise = IRQ_I & ~irq_q.
- Pending update, per source i, evaluated each cycle in this priority order:
  - Set: if mode[i]=1 (edge) and rise[i], or mode[i]=0 (level) and IRQ_I[i].
  - Otherwise clear, if any of:
    - a W1C write to PEND with be[0] and DAT_I[i]=1;
    - an ack clear (ASSERT state, int_ack=1, i==cur_id, mode[i]=1).
  - Set beats clear in the same cycle.
  - A level-mode source re-pends while its line stays high. Software must clear the device before EOI.
- Registers:
  - PEND: read gives pend. Write is W1C.
  - MASK: read/write. 1 = enabled.
  - MODE: read/write. 1 = edge, 0 = level.
  - CUR: read gives {in_svc at bit 7, irq_o at bit 6, cur_id at bits [ID_W-1:0]}. Any write with be[0] is EOI.
- Writes with be[0]=0 are ignored.
- Writes take effect at the clock edge. Reads return the pre-edge value.
- active = pend & mask.
- win = index of the lowest set bit of active.
- FSM states:
  - IDLE: irq_o=0. If active != 0, then cur_id <= win and go to ASSERT. irq_o therefore rises one cycle after pend is visible.
  - ASSERT: irq_o=1.
    - If int_ack, go to SERVICE.
    - Else if active[cur_id]=0 (cleared or masked), retract to IDLE.
    - cur_id is frozen in this state. A higher-priority source arriving now does not pre-empt; it is taken after EOI.
  - SERVICE: irq_o=0, in_svc=1. An EOI write returns to IDLE, and a pending source can reassert on the following cycle. No nesting.
- Ignored events:
  - int_ack outside ASSERT has no effect.
  - EOI outside SERVICE has no effect.
- Simultaneous events:
  - int_ack together with a retract condition in the same cycle: ack wins and the FSM goes to SERVICE.
  - EOI together with a new pend: FSM goes to IDLE, then ASSERT the next cycle.
- Reset asserted mid-handshake returns everything to the reset state immediately.

Test Plan:
1. Reset, then MASK=0x01, MODE=0x01. Pulse IRQ_I[0] for 1 cycle.
   - pend[0]=1 on the next edge; irq_o=1 one cycle later; cur_id=0.
   - int_ack: pend[0]=0, in_svc=1, CUR reads 0x80.
   - EOI write: in_svc=0, irq_o stays 0.
2. Level mode, MASK=0x3F. Hold IRQ_I=0b000110.
   - cur_id=1 is asserted. After ack, pend[1] stays 1.
   - Drop IRQ_I[1], W1C PEND=0x02, then EOI: irq_o reasserts with cur_id=2.
3. Retract: source 3 is in ASSERT; write MASK=0x00 before ack. The FSM returns to IDLE next cycle, irq_o=0, pend[3] is still 1.
4. Priority hold: in ASSERT with cur_id=4, raise IRQ_I[0] (edge mode).
   - cur_id stays 4 until ack.
   - After EOI, cur_id=0 is asserted.
5. Same-cycle edge set and W1C clear on source 2 (edge mode): pend[2] remains 1.
6. Reset pulse while in SERVICE: irq_o=0, in_svc=0, all registers read 0 immediately.
